// File: rtl/core_store_buffer_if.sv
// Data-bus port bundle: one load channel and one store channel.
// The master side drives requests, addresses, byte enables and store data.
// The slave side returns grants and load data.
//   rd_req/rd_gnt/rd_addr/rd_data : load request, grant, byte address, data (cycle after grant)
//   wr_req/wr_gnt/wr_addr/wr_be/wr_data : store request, grant, byte address, byte enables, data
interface core_store_buffer_if;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/core_store_buffer.sv
// Posted-write buffer between the core data-bus port and the system data bus.
// Stores are accepted into a circular FIFO in one cycle and drained in order.
// Loads pass straight through unless they hit a pending store word or target IO
// while stores are pending; such loads are held until the hazard clears.
// Loads win bus arbitration unless a pending drain has starved STARVE_LIMIT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_bus      : core-facing port (slave modport)
//   m_bus      : system-bus port (master modport), m_bus.wr_* always shows the head entry
//   o_count    : number of valid entries (registered)
//   o_empty    : o_count == 0 (registered)
module core_store_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [31:0] IO_BASE      = 32'h8000_0000,
  parameter logic [31:0] IO_MASK      = 32'hF000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  core_store_buffer_if.slave           s_bus,
  core_store_buffer_if.master          m_bus,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;
  logic [STV_W-1:0]   starve_q, starve_d;

  logic addr_hit, io_load, hit, drain_wins, load_want;
  logic rd_req_int, wr_req_int, enq, deq;

  // Word-granular match against every pending store; byte enables are ignored.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (entry_q[i].addr[31:2] == s_bus.rd_addr[31:2])) begin
        addr_hit = 1'b1;
      end
    end
  end

  // Hazard detection and one-request-per-cycle arbitration.
  always_comb begin
    io_load    = (s_bus.rd_addr & IO_MASK) == IO_BASE;
    hit        = addr_hit | (io_load & ~empty_q);
    drain_wins = starve_q == STV_W'(STARVE_LIMIT);
    load_want  = s_bus.rd_req & ~hit;
    rd_req_int = load_want & ~drain_wins;
    wr_req_int = ~empty_q & (~load_want | drain_wins);
    enq        = s_bus.wr_req & (count_q < CNT_W'(DEPTH));
    deq        = wr_req_int & m_bus.wr_gnt;
  end

  assign m_bus.rd_req  = rd_req_int;
  assign m_bus.rd_addr = s_bus.rd_addr;
  assign s_bus.rd_gnt  = rd_req_int & m_bus.rd_gnt;
  assign s_bus.rd_data = m_bus.rd_data;
  assign s_bus.wr_gnt  = enq;
  assign m_bus.wr_req  = wr_req_int;
  assign m_bus.wr_addr = entry_q[rd_ptr_q].addr;
  assign m_bus.wr_be   = entry_q[rd_ptr_q].be;
  assign m_bus.wr_data = entry_q[rd_ptr_q].data;
  assign o_count       = count_q;
  assign o_empty       = empty_q;

  // FIFO and starve-counter next state.
  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (enq) begin
      entry_d[wr_ptr_q] = '{addr: s_bus.wr_addr, be: s_bus.wr_be, data: s_bus.wr_data};
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    // Enqueue and dequeue never target the same slot: full refuses enqueue, empty has no head.
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d = count_d == '0;

    // A load winning the bus is rd_req_int; that already implies the counter is below the limit.
    if (empty_q || deq) begin
      starve_d = '0;
    end else if (rd_req_int) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      starve_q <= '0;
    end else begin
      entry_q  <= entry_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      starve_q <= starve_d;
    end
  end

endmodule
